// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the generic pipeline stage register:
//   - stage_state_e : occupancy state of a stage (EMPTY / BUSY / FULL)
//   - PIPE_DATA_W / PIPE_CTRL_W : default payload and control widths
//   - per-stage control bundles (ex_ctrl_t, mem_ctrl_t, wb_ctrl_t); callers
//     build one of these and cast it into the stage's in_ctrl port
//   - stage_state() : derives the occupancy state from the two valid bits
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int PIPE_DATA_W = 128;
  localparam int PIPE_CTRL_W = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // main entry invalid
    ST_BUSY  = 2'd1,  // main valid, skid invalid
    ST_FULL  = 2'd2   // main and skid both valid
  } stage_state_e;

  // ID/EX control bundle (16 bits, all-zero is a NOP).
  typedef struct packed {
    logic [4:0] rsvd;
    logic       jump;
    logic       branch;
    logic       reg_wr;
    logic       mem_wr;
    logic       mem_rd;
    logic [1:0] src_sel;
    logic [3:0] alu_op;
  } ex_ctrl_t;

  // EX/MEM control bundle (16 bits).
  typedef struct packed {
    logic [10:0] rsvd;
    logic [1:0]  size;
    logic        reg_wr;
    logic        mem_wr;
    logic        mem_rd;
  } mem_ctrl_t;

  // MEM/WB control bundle (16 bits).
  typedef struct packed {
    logic [13:0] rsvd;
    logic        mem_to_reg;
    logic        reg_wr;
  } wb_ctrl_t;

  // The two entry valid bits fully encode the stage occupancy.
  function automatic stage_state_e stage_state(input logic main_valid,
                                               input logic skid_valid);
    if (skid_valid) return ST_FULL;
    if (main_valid) return ST_BUSY;
    return ST_EMPTY;
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// ---------------------------------------------------------------------------
// pipe_entry_reg
// One pipeline entry: a valid bit plus payload and control registers.
//   clk, reset : clock and synchronous active-high reset
//   valid_i    : next value of the valid bit (written every cycle)
//   load_i     : capture data_i / ctrl_i this cycle
//   data_i     : payload to capture
//   ctrl_i     : control bundle to capture
//   valid_o    : entry holds a live beat
//   data_o     : held payload (kept across invalidation)
//   ctrl_o     : held control bundle (kept across invalidation)
// ---------------------------------------------------------------------------
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      // NOTE: the payload is reset as well because the stage output must read
      // zero after reset; outside reset it only changes on load.
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_i;
      if (load_i) begin
        data_q <= data_i;
        ctrl_q <= ctrl_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
// Generic pipeline stage register with valid/ready handshake, optional
// 2-entry skid buffer, flush, and a saturating bubble counter.
//   clk        : clock, all state updates on the rising edge
//   reset      : synchronous active-high reset
//   flush      : kill held entries and any beat accepted this cycle
//   in_valid   : upstream beat present
//   in_ready   : stage can accept a beat (registered when SKID=1)
//   in_data    : upstream payload
//   in_ctrl    : upstream control bundle
//   out_valid  : stage holds a live beat
//   out_ready  : downstream accepts the beat
//   out_data   : head payload
//   out_ctrl   : head control bundle, zero while out_valid=0
//   bubble_clr : synchronous clear of bubble_cnt
//   bubble_cnt : saturating count of cycles with out_valid=0
// ---------------------------------------------------------------------------
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              bubble_clr,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  logic              in_fire;
  logic              out_fire;
  stage_state_e      state;
  stage_state_e      state_d;
  logic              main_load;
  logic              main_from_skid;
  logic              skid_load;
  logic [DATA_W-1:0] main_data_d;
  logic [CTRL_W-1:0] main_ctrl_d;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid & out_ready;
  assign state    = stage_state(main_valid, skid_valid);

  // Next-state and load-enable decode. The entries' valid bits are the only
  // state storage; state_d is turned back into valid bits below.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d        = state;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d   = ST_BUSY;
          main_load = 1'b1;
        end
      end
      ST_BUSY: begin
        if (in_fire && out_fire) begin
          main_load = 1'b1;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end else if (in_fire && SKID != 0) begin
          // Downstream stalled while a new beat arrived: park it in skid.
          state_d   = ST_FULL;
          skid_load = 1'b1;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_d        = ST_BUSY;
          main_load      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Flush drops everything, including a beat accepted this cycle. Loads are
    // suppressed so the held payload keeps its old value.
    if (flush) begin
      state_d   = ST_EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  assign main_data_d = main_from_skid ? skid_data : in_data;
  assign main_ctrl_d = main_from_skid ? skid_ctrl : in_ctrl;

  pipe_entry_reg #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk     (clk),
    .reset   (reset),
    .valid_i (state_d != ST_EMPTY),
    .load_i  (main_load),
    .data_i  (main_data_d),
    .ctrl_i  (main_ctrl_d),
    .valid_o (main_valid),
    .data_o  (main_data),
    .ctrl_o  (main_ctrl)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_q;

      pipe_entry_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
      ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .valid_i (state_d == ST_FULL),
        .load_i  (skid_load),
        .data_i  (in_data),
        .ctrl_i  (in_ctrl),
        .valid_o (skid_valid),
        .data_o  (skid_data),
        .ctrl_o  (skid_ctrl)
      );

      // Registered copy of !skid_valid: breaks the combinational ready path
      // from downstream to upstream.
      always_ff @(posedge clk) begin
        if (reset) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= (state_d != ST_FULL);
        end
      end

      assign in_ready = in_ready_q;
    end else begin : g_no_skid
      assign skid_valid = 1'b0;
      assign skid_data  = '0;
      assign skid_ctrl  = '0;
      // Single entry: accept when empty or when the head leaves this cycle.
      assign in_ready   = ~main_valid | out_ready;
    end
  endgenerate

  // Bubble counter: clear wins over increment; saturates instead of wrapping.
  logic [CNT_W-1:0] bubble_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (bubble_clr) begin
      bubble_cnt_d = '0;
    end else if (!main_valid && bubble_cnt_q != CNT_MAX) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign out_valid  = main_valid;
  assign out_data   = main_data;
  // Output gating keeps the control bundle a NOP while no beat is live.
  assign out_ctrl   = main_valid ? main_ctrl : '0;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid
// Self-checking bench for pipe_stage_skid. Three instances:
//   a : defaults (SKID=1, 128-bit payload, 16-bit counter)
//   b : SKID=0, 32-bit payload
//   c : SKID=1, 8-bit payload, 4-bit counter (saturation)
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int AW = PIPE_DATA_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- instance a ----------------
  logic           rst_a, a_flush, a_iv, a_ir, a_ov, a_ordy, a_bclr;
  logic [AW-1:0]  a_d, a_od;
  logic [15:0]    a_c, a_oc, a_cnt;

  pipe_stage_skid dut_a (
    .clk (clk), .reset (rst_a), .flush (a_flush),
    .in_valid (a_iv), .in_ready (a_ir), .in_data (a_d), .in_ctrl (a_c),
    .out_valid (a_ov), .out_ready (a_ordy), .out_data (a_od), .out_ctrl (a_oc),
    .bubble_clr (a_bclr), .bubble_cnt (a_cnt)
  );

  // ---------------- instance b ----------------
  logic           rst_b, b_flush, b_iv, b_ir, b_ov, b_ordy, b_bclr;
  logic [31:0]    b_d, b_od;
  logic [15:0]    b_c, b_oc, b_cnt;

  pipe_stage_skid #(.DATA_W (32), .CTRL_W (16), .SKID (0), .CNT_W (16)) dut_b (
    .clk (clk), .reset (rst_b), .flush (b_flush),
    .in_valid (b_iv), .in_ready (b_ir), .in_data (b_d), .in_ctrl (b_c),
    .out_valid (b_ov), .out_ready (b_ordy), .out_data (b_od), .out_ctrl (b_oc),
    .bubble_clr (b_bclr), .bubble_cnt (b_cnt)
  );

  // ---------------- instance c ----------------
  logic           rst_c, c_ir, c_ov;
  logic [7:0]     c_od;
  logic [3:0]     c_oc, c_cnt;

  pipe_stage_skid #(.DATA_W (8), .CTRL_W (4), .SKID (1), .CNT_W (4)) dut_c (
    .clk (clk), .reset (rst_c), .flush (1'b0),
    .in_valid (1'b0), .in_ready (c_ir), .in_data (8'h00), .in_ctrl (4'h0),
    .out_valid (c_ov), .out_ready (1'b1), .out_data (c_od), .out_ctrl (c_oc),
    .bubble_clr (1'b0), .bubble_cnt (c_cnt)
  );

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table (instance a) ----------------
  typedef struct {
    logic        iv;
    logic [7:0]  d;
    logic [15:0] c;
    logic        ordy;
    logic        fl;
    logic        e_ov;
    logic [7:0]  e_od;
    logic [15:0] e_oc;
    logic        e_ir;
  } vec_t;

  localparam int NVEC = 18;
  vec_t tbl[NVEC];

  function automatic vec_t mk(input logic iv, input logic [7:0] d,
                              input logic [15:0] c, input logic ordy,
                              input logic fl, input logic e_ov,
                              input logic [7:0] e_od, input logic [15:0] e_oc,
                              input logic e_ir);
    vec_t v;
    v.iv = iv; v.d = d; v.c = c; v.ordy = ordy; v.fl = fl;
    v.e_ov = e_ov; v.e_od = e_od; v.e_oc = e_oc; v.e_ir = e_ir;
    return v;
  endfunction

  // ---------------- reference model (random phase) ----------------
  typedef struct {
    logic [127:0] d;
    logic [15:0]  c;
  } beat_t;

  beat_t qa[$];
  beat_t qb[$];
  int    cnt_am, cnt_bm;
  logic  a_fire_prev, b_fire_prev;

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    // Inputs idle, all instances in reset.
    rst_a = 1'b1; a_flush = 1'b0; a_iv = 1'b0; a_d = '0; a_c = '0;
    a_ordy = 1'b0; a_bclr = 1'b0;
    rst_b = 1'b1; b_flush = 1'b0; b_iv = 1'b0; b_d = '0; b_c = '0;
    b_ordy = 1'b0; b_bclr = 1'b0;
    rst_c = 1'b1;

    // Stimulus table: inputs for one cycle, outputs expected in that cycle.
    //            iv    d      c        ordy  fl  | ov    od     oc       ir
    tbl[0]  = mk(1'b1, 8'hA5, 16'h0003, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
    tbl[1]  = mk(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b1, 8'hA5, 16'h0003, 1'b1);
    tbl[2]  = mk(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 8'hA5, 16'h0000, 1'b1);
    tbl[3]  = mk(1'b1, 8'h01, 16'h0011, 1'b1, 1'b0, 1'b0, 8'hA5, 16'h0000, 1'b1);
    tbl[4]  = mk(1'b1, 8'h02, 16'h0012, 1'b0, 1'b0, 1'b1, 8'h01, 16'h0011, 1'b1);
    tbl[5]  = mk(1'b1, 8'h03, 16'h0013, 1'b0, 1'b0, 1'b1, 8'h01, 16'h0011, 1'b0);
    tbl[6]  = mk(1'b1, 8'h03, 16'h0013, 1'b1, 1'b0, 1'b1, 8'h01, 16'h0011, 1'b0);
    tbl[7]  = mk(1'b1, 8'h03, 16'h0013, 1'b1, 1'b0, 1'b1, 8'h02, 16'h0012, 1'b1);
    tbl[8]  = mk(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h03, 16'h0013, 1'b1);
    tbl[9]  = mk(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h03, 16'h0000, 1'b1);
    tbl[10] = mk(1'b1, 8'h07, 16'h0017, 1'b0, 1'b0, 1'b0, 8'h03, 16'h0000, 1'b1);
    tbl[11] = mk(1'b1, 8'h08, 16'h0018, 1'b0, 1'b0, 1'b1, 8'h07, 16'h0017, 1'b1);
    tbl[12] = mk(1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b1, 8'h07, 16'h0017, 1'b0);
    tbl[13] = mk(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h07, 16'h0000, 1'b1);
    tbl[14] = mk(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h07, 16'h0000, 1'b1);
    tbl[15] = mk(1'b1, 8'h05, 16'h0015, 1'b0, 1'b0, 1'b0, 8'h07, 16'h0000, 1'b1);
    tbl[16] = mk(1'b1, 8'h09, 16'h0019, 1'b0, 1'b1, 1'b1, 8'h05, 16'h0015, 1'b1);
    tbl[17] = mk(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h05, 16'h0000, 1'b1);

    // ---- reset state (instance a) ----
    cyc();
    cyc();
    @(negedge clk);
    check("reset.out_valid", a_ov, 0);
    check("reset.out_data", a_od, 0);
    check("reset.out_ctrl", a_oc, 0);
    check("reset.bubble_cnt", a_cnt, 0);
    cyc();
    rst_a = 1'b0;
    @(negedge clk);
    check("reset.in_ready", a_ir, 1);

    // ---- bubble counter: 5 idle cycles, then clear ----
    repeat (5) cyc();
    @(negedge clk);
    check("bubble.idle5", a_cnt, 5);
    a_bclr = 1'b1;
    cyc();
    a_bclr = 1'b0;
    @(negedge clk);
    check("bubble.clr_priority", a_cnt, 0);
    cyc();

    // ---- directed table ----
    for (int i = 0; i < NVEC; i++) begin
      a_iv = tbl[i].iv;
      a_d = '0;
      a_d[7:0] = tbl[i].d;
      a_c = tbl[i].c;
      a_ordy = tbl[i].ordy;
      a_flush = tbl[i].fl;
      @(negedge clk);
      check($sformatf("vec%0d.out_valid", i), a_ov, tbl[i].e_ov);
      check($sformatf("vec%0d.out_data", i), a_od, tbl[i].e_od);
      check($sformatf("vec%0d.out_ctrl", i), a_oc, tbl[i].e_oc);
      check($sformatf("vec%0d.in_ready", i), a_ir, tbl[i].e_ir);
      cyc();
    end
    a_iv = 1'b0; a_flush = 1'b0; a_ordy = 1'b0;

    // ---- SKID=0: combinational ready and full throughput ----
    rst_b = 1'b0;
    b_iv = 1'b1; b_d = 32'd1; b_c = 16'd1; b_ordy = 1'b0;
    @(negedge clk);
    check("skid0.empty_in_ready", b_ir, 1);
    check("skid0.empty_out_valid", b_ov, 0);
    cyc();
    b_d = 32'd2; b_c = 16'd2;
    @(negedge clk);
    check("skid0.held_out_valid", b_ov, 1);
    check("skid0.held_out_data", b_od, 1);
    check("skid0.stall_in_ready", b_ir, 0);
    b_ordy = 1'b1;
    #1;
    check("skid0.ready_same_cycle", b_ir, 1);
    cyc();
    for (int k = 3; k <= 10; k++) begin
      b_d = 32'(k); b_c = 16'(k);
      @(negedge clk);
      check($sformatf("skid0.stream%0d.out_valid", k), b_ov, 1);
      check($sformatf("skid0.stream%0d.out_data", k), b_od, k - 1);
      check($sformatf("skid0.stream%0d.out_ctrl", k), b_oc, k - 1);
      check($sformatf("skid0.stream%0d.in_ready", k), b_ir, 1);
      cyc();
    end
    b_iv = 1'b0;
    @(negedge clk);
    check("skid0.last.out_data", b_od, 10);
    cyc();
    @(negedge clk);
    check("skid0.drained.out_valid", b_ov, 0);
    check("skid0.drained.out_ctrl", b_oc, 0);
    cyc();

    // ---- CNT_W=4 saturation ----
    rst_c = 1'b0;
    repeat (14) cyc();
    @(negedge clk);
    check("cnt4.idle14", c_cnt, 14);
    repeat (6) cyc();
    @(negedge clk);
    check("cnt4.saturate", c_cnt, 15);
    cyc();

    // ---- randomized run against queue model (instances a and b) ----
    a_fire_prev = 1'b0;
    b_fire_prev = 1'b0;
    cnt_am = 0;
    cnt_bm = 0;
    for (int n = 0; n < 3000; n++) begin
      logic rst;
      int   pct;
      rst = (n == 0 || n == 1500);
      rst_a = rst;
      rst_b = rst;
      pct = ((n / 250) % 2 != 0) ? 85 : 35;

      if (!(a_iv && !a_fire_prev)) begin
        a_iv = ($urandom_range(0, 3) != 0);
        a_d = rnd128();
        a_c = 16'($urandom);
      end
      a_ordy = ($urandom_range(0, 99) < pct);
      a_flush = ($urandom_range(0, 39) == 0);
      a_bclr = ($urandom_range(0, 99) == 0);

      if (!(b_iv && !b_fire_prev)) begin
        b_iv = ($urandom_range(0, 3) != 0);
        b_d = $urandom;
        b_c = 16'($urandom);
      end
      b_ordy = ($urandom_range(0, 99) < pct);
      b_flush = ($urandom_range(0, 39) == 0);
      b_bclr = ($urandom_range(0, 99) == 0);

      @(negedge clk);
      if (n == 1) begin
        check("rand.post_reset.a_out_data", a_od, 0);
        check("rand.post_reset.b_out_data", b_od, 0);
      end
      if (n != 0) begin
        check("rand.a.out_valid", a_ov, qa.size() > 0);
        check("rand.a.in_ready", a_ir, qa.size() < 2);
        check("rand.a.bubble_cnt", a_cnt, cnt_am);
        if (qa.size() > 0) begin
          check("rand.a.out_data", a_od, qa[0].d);
          check("rand.a.out_ctrl", a_oc, qa[0].c);
        end else begin
          check("rand.a.out_ctrl_nop", a_oc, 0);
        end
        check("rand.b.out_valid", b_ov, qb.size() > 0);
        check("rand.b.in_ready", b_ir, qb.size() == 0 || b_ordy);
        check("rand.b.bubble_cnt", b_cnt, cnt_bm);
        if (qb.size() > 0) begin
          check("rand.b.out_data", b_od, qb[0].d);
          check("rand.b.out_ctrl", b_oc, qb[0].c);
        end else begin
          check("rand.b.out_ctrl_nop", b_oc, 0);
        end
      end

      // Model update for the coming edge.
      if (rst) begin
        qa.delete(); qb.delete();
        cnt_am = 0; cnt_bm = 0;
        a_fire_prev = 1'b0; b_fire_prev = 1'b0;
      end else begin
        logic a_in, a_out, b_in, b_out;
        beat_t bt;
        a_in  = a_iv && (qa.size() < 2);
        a_out = (qa.size() > 0) && a_ordy;
        b_in  = b_iv && (qb.size() == 0 || b_ordy);
        b_out = (qb.size() > 0) && b_ordy;

        if (a_bclr) cnt_am = 0;
        else if (qa.size() == 0 && cnt_am < 65535) cnt_am++;
        if (b_bclr) cnt_bm = 0;
        else if (qb.size() == 0 && cnt_bm < 65535) cnt_bm++;

        if (a_flush) qa.delete();
        else begin
          if (a_out) void'(qa.pop_front());
          if (a_in) begin bt.d = a_d; bt.c = a_c; qa.push_back(bt); end
        end
        if (b_flush) qb.delete();
        else begin
          if (b_out) void'(qb.pop_front());
          if (b_in) begin bt.d = 128'(b_d); bt.c = b_c; qb.push_back(bt); end
        end
        a_fire_prev = a_in;
        b_fire_prev = b_in;
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
